// File: rtl/psram_pkg.sv
//==============================================================================
// Module  : psram_pkg
// Brief   : Shared constants and state encoding for the PSRAM arbiter.
// Revision: 1.0
//==============================================================================
`default_nettype none

package psram_pkg;

    localparam int c_aw_default = 22;

    // Byte lane convention: for byte writes, addr[c_byte_sel_bit]=1 selects the upper byte.
    localparam int c_byte_sel_bit = 0;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle      = 2'd0;
    localparam state_t c_st_issue     = 2'd1;
    localparam state_t c_st_wait_busy = 2'd2;
    localparam state_t c_st_wait_done = 2'd3;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//==============================================================================
// Module  : rr_arbiter
// Brief   : Combinational next-grant selection with optional port-0 priority.
// Revision: 1.0
//==============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NPORTS = 3,
    parameter int PRIO0  = 1,
    parameter int IW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic [NPORTS-1:0] i_req,
    input  logic [IW-1:0]     i_last_grant,
    output logic [NPORTS-1:0] o_grant,
    output logic [IW-1:0]     o_grant_idx,
    output logic              o_valid,
    output logic              o_prio
);

    logic [IW-1:0] w_cand;

    always_comb begin
        o_grant_idx = '0;
        o_valid     = 1'b0;
        o_prio      = 1'b0;
        w_cand      = '0;
        if ((PRIO0 != 0) && i_req[0]) begin
            o_valid = 1'b1;
            o_prio  = 1'b1;
        end else begin
            // Scan starts one past the previous winner so the last winner is served last.
            for (int k = 1; k <= NPORTS; k++) begin
                w_cand = IW'((int'(i_last_grant) + k) % NPORTS);
                if (!o_valid && i_req[w_cand]) begin
                    o_valid     = 1'b1;
                    o_grant_idx = w_cand;
                end
            end
        end
        o_grant = o_valid ? (NPORTS'(1) << o_grant_idx) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/psram_arbiter.sv
//==============================================================================
// Module  : psram_arbiter
// Brief   : Serialises NPORTS requesters onto the single-port PSRAM controller.
// Revision: 1.0
//==============================================================================
`default_nettype none

module psram_arbiter
    import psram_pkg::*;
#(
    parameter int NPORTS = 3,
    parameter int AW     = c_aw_default,
    parameter int PRIO0  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS-1:0]    we,
    input  logic [NPORTS-1:0]    byte_write,
    input  logic [NPORTS*AW-1:0] addr,
    input  logic [NPORTS*16-1:0] wdata,
    output logic [NPORTS-1:0]    ack,
    output logic [NPORTS-1:0]    done,
    output logic [15:0]          rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [AW-1:0]        mem_addr,
    output logic [15:0]          mem_din,
    output logic                 mem_byte_write,
    input  logic                 mem_busy,
    input  logic [15:0]          mem_dout
);

    localparam int c_iw = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    state_t              r_state;
    logic [c_iw-1:0]     r_gnt_idx;
    logic                r_gnt_prio;
    logic [c_iw-1:0]     r_last_grant;
    logic                r_we;
    logic [NPORTS-1:0]   r_ack;
    logic [NPORTS-1:0]   r_done;
    logic [15:0]         r_rdata;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [AW-1:0]       r_mem_addr;
    logic [15:0]         r_mem_din;
    logic                r_mem_byte_write;

    logic [NPORTS-1:0]   w_grant;
    logic [c_iw-1:0]     w_grant_idx;
    logic                w_grant_valid;
    logic                w_grant_prio;

    rr_arbiter #(
        .NPORTS (NPORTS),
        .PRIO0  (PRIO0),
        .IW     (c_iw)
    ) u_rr_arbiter (
        .i_req        (req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_valid      (w_grant_valid),
        .o_prio       (w_grant_prio)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= c_st_idle;
            r_gnt_idx        <= '0;
            r_gnt_prio       <= 1'b0;
            r_last_grant     <= c_iw'(NPORTS - 1);
            r_we             <= 1'b0;
            r_ack            <= '0;
            r_done           <= '0;
            r_rdata          <= '0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_din        <= '0;
            r_mem_byte_write <= 1'b0;
        end else begin
            r_ack       <= '0;
            r_done      <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    // Controller busy also covers its post-reset init; hold requests off until then.
                    if (!mem_busy && w_grant_valid) begin
                        r_ack            <= w_grant;
                        r_gnt_idx        <= w_grant_idx;
                        r_gnt_prio       <= w_grant_prio;
                        r_we             <= we[w_grant_idx];
                        r_mem_byte_write <= byte_write[w_grant_idx];
                        r_mem_addr       <= addr[w_grant_idx*AW +: AW];
                        r_mem_din        <= wdata[w_grant_idx*16 +: 16];
                        r_state          <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    r_mem_read  <= ~r_we;
                    r_mem_write <= r_we;
                    r_state     <= c_st_wait_busy;
                end
                c_st_wait_busy: begin
                    if (mem_busy) begin
                        r_state <= c_st_wait_done;
                    end
                end
                c_st_wait_done: begin
                    if (!mem_busy) begin
                        r_done <= NPORTS'(1) << r_gnt_idx;
                        if (!r_we) begin
                            r_rdata <= mem_dout;
                        end
                        // Priority grants of port 0 leave the rotation untouched.
                        if (!r_gnt_prio) begin
                            r_last_grant <= r_gnt_idx;
                        end
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign ack            = r_ack;
    assign done           = r_done;
    assign rdata          = r_rdata;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_addr       = r_mem_addr;
    assign mem_din        = r_mem_din;
    assign mem_byte_write = r_mem_byte_write;

endmodule

`default_nettype wire
